// File: rtl/store_buffer_if.sv
// Pipeline / data-memory side signals of the store buffer.
// master = pipeline + memory environment, slave = the buffer itself.
interface store_buffer_if #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                     sig_mem_write_m;
    logic                     sig_mem_read_m;
    logic [ADDR_W-1:0]        addr_m;
    logic [DATA_W-1:0]        write_data_m;
    logic                     sig_stall;
    logic                     fwd_hit;
    logic [DATA_W-1:0]        fwd_data;
    logic                     mem_req;
    logic [ADDR_W-1:0]        mem_addr;
    logic [DATA_W-1:0]        mem_wdata;
    logic                     mem_ack;
    logic                     empty;
    logic [$clog2(DEPTH):0]   count;

    modport master (
        output sig_mem_write_m, sig_mem_read_m, addr_m, write_data_m, mem_ack,
        input  sig_stall, fwd_hit, fwd_data, mem_req, mem_addr, mem_wdata, empty, count
    );

    modport slave (
        input  sig_mem_write_m, sig_mem_read_m, addr_m, write_data_m, mem_ack,
        output sig_stall, fwd_hit, fwd_data, mem_req, mem_addr, mem_wdata, empty, count
    );
endinterface

// File: rtl/store_buffer.sv
// Posted-write FIFO between the M stage and data memory, with load forwarding.
// Optional STORE_BUFFER_COALESCE_EN: stores hitting a non-head entry update it in place.
module store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    store_buffer_if.slave     sb
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] addrQ [DEPTH];
    logic [DATA_W-1:0] dataQ [DEPTH];
    logic [PTR_W-1:0]  headPtr, tailPtr;
    logic [CNT_W-1:0]  occ;

    logic              full, isEmpty, doEnq, doPop, coalHit;
    logic              fwdMatch;
    logic [DATA_W-1:0] fwdWord;

    assign full    = (occ == CNT_W'(DEPTH));
    assign isEmpty = (occ == '0);

    // Oldest-to-youngest scan so the last hit is the youngest matching store.
    always_comb begin
        fwdMatch = 1'b0;
        fwdWord  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if ((CNT_W'(k) < occ) &&
                (addrQ[headPtr + PTR_W'(k)][ADDR_W-1:2] == sb.addr_m[ADDR_W-1:2])) begin
                fwdMatch = 1'b1;
                fwdWord  = dataQ[headPtr + PTR_W'(k)];
            end
        end
    end

`ifdef STORE_BUFFER_COALESCE_EN
    logic [PTR_W-1:0] coalIdx;

    // Head is excluded so the word being offered to memory never changes under mem_req.
    always_comb begin
        coalHit = 1'b0;
        coalIdx = '0;
        if (sb.sig_mem_write_m) begin
            for (int k = 1; k < DEPTH; k++) begin
                if ((CNT_W'(k) < occ) &&
                    (addrQ[headPtr + PTR_W'(k)][ADDR_W-1:2] == sb.addr_m[ADDR_W-1:2])) begin
                    coalHit = 1'b1;
                    coalIdx = headPtr + PTR_W'(k);
                end
            end
        end
    end
`else
    assign coalHit = 1'b0;
`endif

    assign doEnq = sb.sig_mem_write_m & ~full & ~coalHit;
    assign doPop = ~isEmpty & sb.mem_ack;

    assign sb.sig_stall = sb.sig_mem_write_m & full & ~coalHit;
    assign sb.mem_req   = ~isEmpty;
    assign sb.mem_addr  = isEmpty ? '0 : addrQ[headPtr];
    assign sb.mem_wdata = isEmpty ? '0 : dataQ[headPtr];
    assign sb.fwd_hit   = sb.sig_mem_read_m & ~sb.sig_mem_write_m & fwdMatch;
    assign sb.fwd_data  = sb.fwd_hit ? fwdWord : '0;
    assign sb.empty     = isEmpty;
    assign sb.count     = occ;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            headPtr <= '0;
            tailPtr <= '0;
            occ     <= '0;
        end else begin
            if (doEnq) tailPtr <= tailPtr + 1'b1;
            if (doPop) headPtr <= headPtr + 1'b1;
            occ <= occ + CNT_W'(doEnq) - CNT_W'(doPop);
        end
    end

    // Entry payload needs no reset: occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (doEnq) begin
            addrQ[tailPtr] <= sb.addr_m;
            dataQ[tailPtr] <= sb.write_data_m;
        end
`ifdef STORE_BUFFER_COALESCE_EN
        if (coalHit) begin
            addrQ[coalIdx] <= sb.addr_m;
            dataQ[coalIdx] <= sb.write_data_m;
        end
`endif
    end
endmodule

// File: tb/tb_store_buffer.sv
// Store buffer bench: directed scenarios plus random traffic, all outputs
// compared each cycle against a queue-based model of the buffer.
module tb_store_buffer;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    store_buffer_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) sbIf ();

    store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sb    (sbIf.slave)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } sbEntry;

    sbEntry model[$];
    int nChecks = 0;
    int nPass   = 0;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Index of the youngest queued store with the same word address, searching down to 'from'.
    function automatic int youngestMatch(input logic [31:0] a, input int from);
        for (int i = model.size() - 1; i >= from; i--)
            if (model[i].addr[31:2] == a[31:2]) return i;
        return -1;
    endfunction

    task automatic checkResetState(input string pfx);
        checkVal({pfx, "_count"},     sbIf.count,     0);
        checkVal({pfx, "_empty"},     sbIf.empty,     1);
        checkVal({pfx, "_mem_req"},   sbIf.mem_req,   0);
        checkVal({pfx, "_mem_addr"},  sbIf.mem_addr,  0);
        checkVal({pfx, "_mem_wdata"}, sbIf.mem_wdata, 0);
        checkVal({pfx, "_fwd_hit"},   sbIf.fwd_hit,   0);
        checkVal({pfx, "_fwd_data"},  sbIf.fwd_data,  0);
        checkVal({pfx, "_sig_stall"}, sbIf.sig_stall, 0);
    endtask

    // Called at a falling edge: drive, check combinational outputs, clock, update model.
    task automatic cycle(input logic wr, input logic rd, input logic [31:0] a,
                         input logic [31:0] d, input logic ack);
        int  hitIdx;
        int  coalIdx;
        bit  stallExp, enq, pop;
        sbIf.sig_mem_write_m = wr;
        sbIf.sig_mem_read_m  = rd;
        sbIf.addr_m          = a;
        sbIf.write_data_m    = d;
        sbIf.mem_ack         = ack;
        #2;
        coalIdx = -1;
`ifdef STORE_BUFFER_COALESCE_EN
        if (wr) coalIdx = youngestMatch(a, 1);
`endif
        stallExp = wr && (model.size() == DEPTH) && (coalIdx < 0);
        checkVal("count",     sbIf.count,     model.size());
        checkVal("empty",     sbIf.empty,     model.size() == 0);
        checkVal("mem_req",   sbIf.mem_req,   model.size() != 0);
        if (model.size() != 0) begin
            checkVal("mem_addr",  sbIf.mem_addr,  model[0].addr);
            checkVal("mem_wdata", sbIf.mem_wdata, model[0].data);
        end
        checkVal("sig_stall", sbIf.sig_stall, stallExp);
        if (rd && !wr) begin
            hitIdx = youngestMatch(a, 0);
            checkVal("fwd_hit",  sbIf.fwd_hit,  hitIdx >= 0);
            checkVal("fwd_data", sbIf.fwd_data, (hitIdx >= 0) ? model[hitIdx].data : 32'h0);
        end else begin
            checkVal("fwd_hit_off", sbIf.fwd_hit, 0);
            if (!rd) checkVal("fwd_data_off", sbIf.fwd_data, 0);
        end
        @(posedge clk);
        pop = (model.size() != 0) && ack;
        enq = wr && !stallExp && (coalIdx < 0);
        if (coalIdx >= 0) model[coalIdx] = '{a, d};
        if (pop) void'(model.pop_front());
        if (enq) model.push_back('{a, d});
        @(negedge clk);
    endtask

    task automatic idle(input logic ack);
        cycle(1'b0, 1'b0, 32'h0, 32'h0, ack);
    endtask

    task automatic drainAll(input string tag);
        for (int i = 0; i < 40 && model.size() != 0; i++) idle(1'b1);
        checkVal({tag, "_drained"}, sbIf.empty, 1);
    endtask

    initial begin
        rst_n = 1'b0;
        sbIf.sig_mem_write_m = 1'b0;
        sbIf.sig_mem_read_m  = 1'b0;
        sbIf.addr_m          = '0;
        sbIf.write_data_m    = '0;
        sbIf.mem_ack         = 1'b0;
        #1;
        checkResetState("rst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single store drains with ack tied high
        cycle(1'b1, 1'b0, 32'h7FF0_0000, 32'hDEAD_BEEF, 1'b1);
        checkVal("t1_req_next",   sbIf.mem_req,   1);
        checkVal("t1_addr_next",  sbIf.mem_addr,  32'h7FF0_0000);
        checkVal("t1_wdata_next", sbIf.mem_wdata, 32'hDEAD_BEEF);
        idle(1'b1);
        checkVal("t1_empty_after", sbIf.empty, 1);

        // Fill, stall on the fifth store, then release with one ack
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 1'b0, 32'h7FF0_0000 + 32'(i * 4), 32'h100 + 32'(i), 1'b0);
        checkVal("t2_full_count", sbIf.count, 4);
        cycle(1'b1, 1'b0, 32'h7FF0_0010, 32'h104, 1'b0);
        cycle(1'b1, 1'b0, 32'h7FF0_0010, 32'h104, 1'b1);
        cycle(1'b1, 1'b0, 32'h7FF0_0010, 32'h104, 1'b0);
        checkVal("t2_refill_count", sbIf.count, 4);
        checkVal("t2_head_after",   sbIf.mem_addr, 32'h7FF0_0004);
        drainAll("t2");

        // Forwarding picks the youngest match, byte offset ignored
        cycle(1'b1, 1'b0, 32'h7FF0_0004, 32'h11, 1'b0);
        cycle(1'b1, 1'b0, 32'h7FF0_0004, 32'h22, 1'b0);
        cycle(1'b0, 1'b1, 32'h7FF0_0006, 32'h0, 1'b0);
        cycle(1'b0, 1'b1, 32'h7FF0_0008, 32'h0, 1'b0);
        cycle(1'b1, 1'b1, 32'h7FF0_0004, 32'h33, 1'b0);
        drainAll("t3");

        // Same-edge enqueue/pop, then wrap with back-to-back stores
        cycle(1'b1, 1'b0, 32'h7FF0_0020, 32'hA0, 1'b0);
        cycle(1'b1, 1'b0, 32'h7FF0_0024, 32'hA1, 1'b0);
        cycle(1'b1, 1'b0, 32'h7FF0_0028, 32'hA2, 1'b1);
        checkVal("t4_same_edge_count", sbIf.count, 2);
        drainAll("t4a");
        for (int i = 0; i < 9; i++)
            cycle(1'b1, 1'b0, 32'h7FF0_0040 + 32'(i * 4), 32'hB0 + 32'(i), 1'b1);
        drainAll("t4b");

        // Asynchronous reset in the middle of a drain
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 1'b0, 32'h7FF0_0060 + 32'(i * 4), 32'hC0 + 32'(i), 1'b0);
        checkVal("t5_pre_req", sbIf.mem_req, 1);
        sbIf.sig_mem_write_m = 1'b0;
        sbIf.sig_mem_read_m  = 1'b0;
        sbIf.mem_ack         = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checkResetState("t5_async");
        model.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) idle(1'b1);

`ifdef STORE_BUFFER_COALESCE_EN
        // Coalescing into the youngest entry while full
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 1'b0, 32'h7FF0_0080 + 32'(i * 4), 32'hD0 + 32'(i), 1'b0);
        cycle(1'b1, 1'b0, 32'h7FF0_008C, 32'h55, 1'b0);
        checkVal("t6_count", sbIf.count, 4);
        drainAll("t6");
`endif

        // Random traffic over a small address window to provoke matches
        for (int n = 0; n < 1500; n++) begin
            logic        wr, rd, ack;
            logic [31:0] a;
            wr  = ($urandom_range(0, 99) < 45);
            rd  = wr ? ($urandom_range(0, 99) < 5) : ($urandom_range(0, 99) < 50);
            ack = ($urandom_range(0, 99) < 40);
            a   = 32'h7FF0_0000 | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
            cycle(wr, rd, a, $urandom, ack);
        end
        drainAll("rand");

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
